// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the async FIFO read-side stream.
// Occupancy encoding doubles as the buffered word count.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int DSIZE_DEF = 8;
    localparam int CNTW_DEF  = 16;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream bundle leaving the FIFO read side.
// master drives data/valid, slave drives ready.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);

    logic [DSIZE-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer with occupancy FSM.
// Entry 0 is the head; a dequeue shifts entry 1 forward.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [DSIZE-1:0] data_in,
    input  logic             deq,
    output occ_e             occ,
    output logic [DSIZE-1:0] head
);

    occ_e             occ_q, occ_n;
    logic [DSIZE-1:0] e0_q, e0_n;
    logic [DSIZE-1:0] e1_q, e1_n;

    // State and entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= OCC_EMPTY;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            occ_q <= occ_n;
            e0_q  <= e0_n;
            e1_q  <= e1_n;
        end
    end

    // Next occupancy and slot loads; a push lands in the first free slot
    // after any same-cycle dequeue.
    always_comb begin
        occ_n = occ_q;
        e0_n  = e0_q;
        e1_n  = e1_q;
        if (clear) begin
            occ_n = OCC_EMPTY;
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        occ_n = OCC_ONE;
                        e0_n  = data_in;
                    end
                end
                OCC_ONE: begin
                    if (push && deq) begin
                        e0_n = data_in;
                    end else if (push) begin
                        occ_n = OCC_TWO;
                        e1_n  = data_in;
                    end else if (deq) begin
                        occ_n = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (deq) begin
                        occ_n = OCC_ONE;
                        e0_n  = e1_q;
                    end
                end
                default: occ_n = OCC_EMPTY;
            endcase
        end
    end

    assign occ  = occ_q;
    assign head = e0_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Async FIFO read-side consumer: pops words into a 2-entry buffer and
// presents them as a registered stream, with flush and word counters.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [DSIZE-1:0]      rdata,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic                  flush,
    fifo_rd_stream_if.master      st,
    output logic [CNTW-1:0]       out_cnt,
    output logic [CNTW-1:0]       drop_cnt,
    output logic                  busy
);

    occ_e       occ;
    logic [1:0] occ_bits;
    logic       push;
    logic       deq;

    // Pop depends only on registered state, never on out_ready.
    assign rinc     = !rrst && !rempty && (flush || occ != OCC_TWO);
    assign push     = rinc && !flush;
    assign deq      = st.out_valid && st.out_ready && !flush;
    assign occ_bits = occ;

    assign st.out_valid = (occ != OCC_EMPTY);
    assign busy         = (occ != OCC_EMPTY) || !rempty;

    rd_skid_buf #(
        .DSIZE(DSIZE)
    ) u_buf (
        .clk    (rclk),
        .rst    (rrst),
        .clear  (flush),
        .push   (push),
        .data_in(rdata),
        .deq    (deq),
        .occ    (occ),
        .head   (st.out_data)
    );

    // Delivered and dropped word counters, wrapping silently.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (deq) begin
                out_cnt <= out_cnt + 1'b1;
            end
            if (flush) begin
                drop_cnt <= drop_cnt + CNTW'(occ_bits) + CNTW'(rinc);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised and directed bench for fifo_rd_stream against a queue model.
// A second instance with 4-bit counters shares the stimulus.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rrst;
    logic       flush;
    logic       ready;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc, rinc2;
    logic       busy, busy2;
    logic [15:0] out_cnt, drop_cnt;
    logic [3:0]  oc2, dc2;

    fifo_rd_stream_if #(.DSIZE(8)) s0 ();
    fifo_rd_stream_if #(.DSIZE(8)) s1 ();

    assign s0.out_ready = ready;
    assign s1.out_ready = ready;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DSIZE(8), .CNTW(16)) dut (
        .rclk    (clk),
        .rrst    (rrst),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .flush   (flush),
        .st      (s0.master),
        .out_cnt (out_cnt),
        .drop_cnt(drop_cnt),
        .busy    (busy)
    );

    fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut4 (
        .rclk    (clk),
        .rrst    (rrst),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc2),
        .flush   (flush),
        .st      (s1.master),
        .out_cnt (oc2),
        .drop_cnt(dc2),
        .busy    (busy2)
    );

    logic [7:0]  fq[$];
    logic [7:0]  bq[$];
    int unsigned mcnt;
    int unsigned mdrop;
    int          total;
    int          passed;
    int          fails;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic rd);
        logic erinc;
        @(negedge clk);
        rrst   = r;
        flush  = f;
        ready  = rd;
        rempty = (fq.size() == 0);
        rdata  = rempty ? 8'($urandom) : fq[0];
        #1;
        erinc = !r && !rempty && (f || bq.size() < 2);
        chk("rinc", {31'd0, rinc}, {31'd0, erinc});
        chk("rinc_w4", {31'd0, rinc2}, {31'd0, erinc});
        chk("busy", {31'd0, busy}, {31'd0, (bq.size() != 0) || !rempty});
        @(posedge clk);
        if (r) begin
            bq.delete();
            mcnt  = 0;
            mdrop = 0;
        end else if (f) begin
            mdrop += bq.size() + (erinc ? 1 : 0);
            bq.delete();
            if (erinc) void'(fq.pop_front());
        end else begin
            if (bq.size() != 0 && rd) begin
                void'(bq.pop_front());
                mcnt++;
            end
            if (erinc) bq.push_back(fq.pop_front());
        end
        #1;
        chk("valid", {31'd0, s0.out_valid}, {31'd0, bq.size() != 0});
        if (bq.size() != 0)
            chk("data", {24'd0, s0.out_data}, {24'd0, bq[0]});
        if (r)
            chk("data_rst", {24'd0, s0.out_data}, 32'd0);
        chk("out_cnt", {16'd0, out_cnt}, {16'd0, mcnt[15:0]});
        chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, mdrop[15:0]});
        chk("out_cnt_w4", {28'd0, oc2}, {28'd0, mcnt[3:0]});
        chk("drop_cnt_w4", {28'd0, dc2}, {28'd0, mdrop[3:0]});
    endtask

    initial begin
        total  = 0;
        passed = 0;
        fails  = 0;
        mcnt   = 0;
        mdrop  = 0;
        rrst   = 1'b1;
        flush  = 1'b0;
        ready  = 1'b0;
        rempty = 1'b1;
        rdata  = 8'h00;
        @(posedge clk);
        #1;

        // Reset held with a word waiting: nothing may be popped.
        fq.push_back(8'hA5);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        // Single word latency.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Back-to-back stream.
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);

        // Backpressure then release.
        fq.push_back(8'h10);
        fq.push_back(8'h11);
        fq.push_back(8'h12);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

        // Fill to TWO with three words left, then flush.
        for (int i = 0; i < 5; i++) fq.push_back(8'($urandom));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 1'b0, 1'b1);

        // Reset mid-operation, then resume.
        fq.push_back(8'h31);
        fq.push_back(8'h32);
        fq.push_back(8'h33);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);

        // Seventeen deliveries wrap the 4-bit counter to 1.
        fq.delete();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) fq.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
        chk("wrap_w4", {28'd0, oc2}, 32'd1);
        chk("cnt17", {16'd0, out_cnt}, 32'd17);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (fq.size() < 6 && $urandom_range(0, 2) != 0)
                fq.push_back(8'($urandom));
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
